// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle add/sub, 1-bit-per-cycle serial shifter for sll/sllv/srav,
// valid/ready handshake on both the operation and the result side.
module alu_seq_exec #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUSel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   Shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Ovf,
  output logic             Err
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLLV = 4'd3;
  localparam logic [3:0] OP_SRAV = 4'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [SHW-1:0]   cnt_q;
  logic             arith_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;
  logic             err_q;

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] diff_c;
  logic             add_ovf_c;
  logic             sub_ovf_c;
  logic [SHW-1:0]   amt_c;
  logic [WIDTH-1:0] sh_next_c;

  // Arithmetic on the live inputs (only consumed on the accept edge) and one serial shift step.
  always_comb begin
    sum_c     = A + B;
    diff_c    = A - B;
    add_ovf_c = (A[WIDTH-1] == B[WIDTH-1]) && (sum_c[WIDTH-1] != A[WIDTH-1]);
    sub_ovf_c = (A[WIDTH-1] != B[WIDTH-1]) && (diff_c[WIDTH-1] != A[WIDTH-1]);
    amt_c     = (ALUSel == OP_SLL) ? Shamt : A[SHW-1:0];
    sh_next_c = arith_q ? {sh_q[WIDTH-1], sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], 1'b0};
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign Zero      = zero_q;
  assign Ovf       = ovf_q;
  assign Err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      arith_q     <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            case (ALUSel)
              OP_ADD: begin
                result_q    <= sum_c;
                zero_q      <= (sum_c == '0);
                ovf_q       <= add_ovf_c;
                err_q       <= 1'b0;
                out_valid_q <= 1'b1;
                state_q     <= DONE;
              end
              OP_SUB: begin
                result_q    <= diff_c;
                zero_q      <= (diff_c == '0);
                ovf_q       <= sub_ovf_c;
                err_q       <= 1'b0;
                out_valid_q <= 1'b1;
                state_q     <= DONE;
              end
              OP_SLL, OP_SLLV, OP_SRAV: begin
                // Zero-length shifts bypass the serial engine.
                if (amt_c == '0) begin
                  result_q    <= B;
                  zero_q      <= (B == '0);
                  ovf_q       <= 1'b0;
                  err_q       <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
                end else begin
                  sh_q    <= B;
                  cnt_q   <= amt_c;
                  arith_q <= (ALUSel == OP_SRAV);
                  state_q <= SHIFT;
                end
              end
              default: begin
                result_q    <= '0;
                zero_q      <= 1'b1;
                ovf_q       <= 1'b0;
                err_q       <= 1'b1;
                out_valid_q <= 1'b1;
                state_q     <= DONE;
              end
            endcase
          end
        end
        SHIFT: begin
          sh_q  <= sh_next_c;
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            result_q    <= sh_next_c;
            zero_q      <= (sh_next_c == '0);
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule
